muldiv_unit: RTL

// Multi-cycle signed multiply/divide unit. It is the execute-stage consumer of the
// ALU-control codes MULT (3'b011) and DIV (3'b100) produced by the ALU decoder.
// It runs the iterative shift-add multiply or restoring divide while the pipeline stalls
// on busy, then posts the results to the HI/LO registers.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 34 +++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU-control codes and the mul/div FSM state type.
package mips_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MULT = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_t;

  function automatic logic is_muldiv_op(input logic [2:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Turns the unsigned magnitude result held in the accumulator into the signed HI/LO pair.
module muldiv_signfix
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,     // MULT: product; DIV: {remainder, quotient}
  input  logic               is_div_i,
  input  logic               div_zero_i,
  input  logic               neg_res_i,  // sign(a) ^ sign(b)
  input  logic               neg_rem_i,  // sign(a), remainder follows the dividend
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_res_i ? -acc_i : acc_i;
    // Divide-by-zero quotient is the all-ones marker and must not be sign-corrected.
    quo  = (neg_res_i && !div_zero_i) ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
    rem  = neg_rem_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
    if (is_div_i) begin
      hi_o = rem;
      lo_o = quo;
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit feeding HI/LO.
// One iteration per CALC cycle; a FIX cycle applies signs before the DONE pulse.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               launch;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign launch = start && is_muldiv_op(alucontrol) && !cancel &&
                  (state_q == MD_IDLE || state_q == MD_DONE);
  assign a_mag  = srca[WIDTH-1] ? -srca : srca;
  assign b_mag  = srcb[WIDTH-1] ? -srcb : srcb;

  // MULT: acc = {partial product, remaining multiplier bits}.
  // DIV:  acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (!is_div_q)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .acc_i      (acc_q),
    .is_div_i   (is_div_q),
    .div_zero_i (div_zero_q),
    .neg_res_i  (neg_res_q),
    .neg_rem_i  (neg_rem_q),
    .hi_o       (fix_hi),
    .lo_o       (fix_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (launch) begin
          is_div_d   = (alucontrol == ALU_DIV);
          div_zero_d = (alucontrol == ALU_DIV) && (srcb == '0);
          neg_res_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
          neg_rem_d  = srca[WIDTH-1];
          cnt_d      = CW'(WIDTH - 1);
          if (alucontrol == ALU_DIV) begin
            opnd_d = b_mag;
            if (srcb == '0) begin
              // Skip iteration: remainder = |a| (re-signed in FIX), quotient = all ones.
              acc_d   = {a_mag, {WIDTH{1'b1}}};
              state_d = MD_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              state_d = MD_CALC;
            end
          end else begin
            opnd_d  = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
